// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit universal register. Each enabled cycle it can hold,
// load, shift left/right, count up/down modulo MOD, apply per-bit JK
// updates, or clear. tc is a registered one-cycle pulse after a count wrap.
module univ_reg #(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] k,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   typedef enum logic [2:0] {
      M_HOLD  = 3'b000,
      M_LOAD  = 3'b001,
      M_SHL   = 3'b010,
      M_SHR   = 3'b011,
      M_UP    = 3'b100,
      M_DOWN  = 3'b101,
      M_JK    = 3'b110,
      M_CLEAR = 3'b111
   } mode_e;

   // Top count value; when MOD = 2^WIDTH this is all ones, so the up-count
   // wrap coincides with natural overflow.
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   mode_e            mode_s;

   assign mode_s = mode_e'(mode);

   // Next-state selection; tc_d defaults low so only a wrapping count edge raises it.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      if (en) begin
         unique case (mode_s)
            M_HOLD:  q_d = q_q;
            M_LOAD:  q_d = d;
            M_SHL:   q_d = {q_q[WIDTH-2:0], sin_l};
            M_SHR:   q_d = {sin_r, q_q[WIDTH-1:1]};
            M_UP: begin
               // Out-of-range values also wrap to zero and pulse tc.
               if (q_q >= MAXV) begin
                  q_d  = '0;
                  tc_d = 1'b1;
               end else begin
                  q_d = q_q + ONE;
               end
            end
            M_DOWN: begin
               // Out-of-range values snap to the top count without a pulse.
               if (q_q == '0) begin
                  q_d  = MAXV;
                  tc_d = 1'b1;
               end else if (q_q > MAXV) begin
                  q_d = MAXV;
               end else begin
                  q_d = q_q - ONE;
               end
            end
            M_JK:    q_d = (d & ~q_q) | (~k & q_q);
            M_CLEAR: q_d = '0;
            default: q_d = q_q;
         endcase
      end
   end

   // State register with synchronous reset overriding every operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign q  = q_q;
   assign tc = tc_q;

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed test-plan steps followed by random cycles, every
// edge checked against an integer-arithmetic model of the register.
module tb_univ_reg;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;
   localparam int RANGE = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [2:0]       mode = 3'b000;
   logic [WIDTH-1:0] d = '0;
   logic [WIDTH-1:0] k = '0;
   logic             sin_l = 1'b0;
   logic             sin_r = 1'b0;
   logic [WIDTH-1:0] q;
   logic             tc;

   int vectors = 0;
   int miscompares = 0;

   // Reference state
   int m_q  = 0;
   int m_tc = 0;

   univ_reg #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .d     (d),
      .k     (k),
      .sin_l (sin_l),
      .sin_r (sin_r),
      .q     (q),
      .tc    (tc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the reference model by one edge using the inputs now driven.
   task automatic model_step();
      int nq;
      int ntc;
      nq  = m_q;
      ntc = 0;
      if (rst) begin
         nq = 0;
      end else if (en) begin
         case (mode)
            3'd0: nq = m_q;
            3'd1: nq = int'(d);
            3'd2: nq = (m_q * 2 + int'(sin_l)) % RANGE;
            3'd3: nq = int'(sin_r) * (RANGE / 2) + m_q / 2;
            3'd4: begin
               if (m_q >= MOD - 1) begin nq = 0; ntc = 1; end
               else nq = m_q + 1;
            end
            3'd5: begin
               if (m_q == 0) begin nq = MOD - 1; ntc = 1; end
               else if (m_q > MOD - 1) nq = MOD - 1;
               else nq = m_q - 1;
            end
            3'd6: begin
               nq = 0;
               for (int b = 0; b < WIDTH; b++) begin
                  int bit_now;
                  int bit_next;
                  bit_now = (m_q >> b) & 1;
                  if (d[b] && k[b])      bit_next = 1 - bit_now;
                  else if (d[b])         bit_next = 1;
                  else if (k[b])         bit_next = 0;
                  else                   bit_next = bit_now;
                  nq += bit_next << b;
               end
            end
            default: nq = 0;
         endcase
      end
      m_q  = nq;
      m_tc = ntc;
   endtask

   // Drive one cycle of inputs, clock it, and compare DUT to the model.
   task automatic apply(input logic r, input logic e, input logic [2:0] m,
                        input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] kk,
                        input logic sl, input logic sr);
      rst = r; en = e; mode = m; d = dd; k = kk; sin_l = sl; sin_r = sr;
      @(posedge clk);
      model_step();
      #1;
      chk("model_q", 8'(q), 8'(m_q));
      chk("model_tc", 8'(tc), 8'(m_tc));
   endtask

   task automatic expect_const(input string tag, input int eq, input int etc);
      chk({tag, "_q"}, 8'(q), 8'(eq));
      chk({tag, "_tc"}, 8'(tc), 8'(etc));
   endtask

   initial begin
      // Reset with random inputs, en=1
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b1, 3'($urandom_range(7)), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
         expect_const("reset", 0, 0);
      end
      apply(1'b0, 1'b1, 3'd1, 4'd7, 4'd0, 1'b0, 1'b0);
      expect_const("post_reset_load", 7, 0);
      apply(1'b0, 1'b1, 3'd7, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("clear", 0, 0);

      // Up-count through the wrap
      for (int i = 1; i <= 12; i++) begin
         apply(1'b0, 1'b1, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
         expect_const("up", i % MOD, (i == MOD) ? 1 : 0);
      end
      apply(1'b0, 1'b1, 3'd1, 4'd13, 4'd0, 1'b0, 1'b0);
      expect_const("load13", 13, 0);
      apply(1'b0, 1'b1, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("up_oor", 0, 1);

      // Down-count
      apply(1'b0, 1'b1, 3'd1, 4'd1, 4'd0, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 3'd5, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("down0", 0, 0);
      apply(1'b0, 1'b1, 3'd5, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("down_wrap", 9, 1);
      apply(1'b0, 1'b1, 3'd5, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("down8", 8, 0);
      apply(1'b0, 1'b1, 3'd1, 4'd15, 4'd0, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 3'd5, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("down_oor", 9, 0);

      // Count-up wrap immediately followed by a load
      apply(1'b0, 1'b1, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("wrap_then", 0, 1);
      apply(1'b0, 1'b1, 3'd1, 4'd6, 4'd0, 1'b0, 1'b0);
      expect_const("load_after_wrap", 6, 0);

      // Shifts
      apply(1'b0, 1'b1, 3'd1, 4'b1001, 4'd0, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 3'd2, 4'd0, 4'd0, 1'b1, 1'b0);
      expect_const("shl", 4'b0011, 0);
      apply(1'b0, 1'b1, 3'd3, 4'd0, 4'd0, 1'b0, 1'b1);
      expect_const("shr1", 4'b1001, 0);
      apply(1'b0, 1'b1, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("shr0", 4'b0100, 0);

      // JK
      apply(1'b0, 1'b1, 3'd1, 4'b1010, 4'd0, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 3'd6, 4'b1100, 4'b0110, 1'b0, 1'b0);
      expect_const("jk", 4'b1100, 0);
      apply(1'b0, 1'b1, 3'd6, 4'b1111, 4'b1111, 1'b0, 1'b0);
      expect_const("jk_toggle", 4'b0011, 0);

      // Enable / reset interaction
      apply(1'b0, 1'b1, 3'd7, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("up5", 5, 0);
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b0, 3'd4, 4'($urandom), 4'($urandom), 1'b1, 1'b1);
         expect_const("en_low", 5, 0);
      end
      apply(1'b1, 1'b1, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
      expect_const("rst_mid", 0, 0);

      // Random cycles against the model
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(31) == 0), ($urandom_range(7) != 0),
               3'($urandom_range(7)), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register: a synchronous WIDTH-bit register that, per cycle, holds, parallel-loads, shifts left or right with serial inputs, counts up or down modulo MOD, applies per-bit JK flip-flop updates, or clears. It is the generalised successor to the team's single-bit D and JK flip-flops and 4-bit adders, and serves as the common counter, shift-register and bit-flag primitive in datapaths.

## Interface
- WIDTH, 4, register width in bits (≥2)
- MOD, 16, counter modulus; legal range 2 ≤ MOD ≤ 2^WIDTH
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  operation enable; 0 = hold
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data; J inputs in JK mode
- k  input  WIDTH  K inputs in JK mode; ignored otherwise
- sin_l  input  1  serial input shifted into bit 0 on shift-left
- sin_r  input  1  serial input shifted into bit WIDTH-1 on shift-right
- q  output  WIDTH  register contents
- tc  output  1  registered terminal-count pulse

## Operation
- Priority: rst > en > mode.
- rst=1: q←0, tc←0, regardless of en/mode.
- en=0: q holds, tc←0.
- en=1, mode:
  - 000 hold: q unchanged.
  - 001 load: q←d; values ≥ MOD are loaded unmodified.
  - 010 shift-left: q←{q[WIDTH-2:0], sin_l}.
  - 011 shift-right: q←{sin_r, q[WIDTH-1:1]}.
  - 100 count-up: if q ≥ MOD-1 then q←0 and tc←1; else q←q+1.
  - 101 count-down: if q==0 then q←MOD-1 and tc←1; if q > MOD-1 then q←MOD-1 and tc←0; else q←q-1.
  - 110 JK: per bit i, q[i]←(d[i]&~q[i])|(~k[i]&q[i]); J=K=1 toggles, J=K=0 holds.
  - 111 clear: q←0.
- tc is 1 only in the cycle following a wrapping count edge; every other edge writes tc←0, including hold, load, shift, JK and clear modes.
- Count arithmetic is WIDTH bits with no overflow beyond the modulus check. When MOD=2^WIDTH, wrap is natural overflow.
- Shifts ignore MOD. Out-of-range values are legal in q.

## Timing
- Single clock domain; every output is registered. There is no combinational path from inputs to q or tc.
- Latency is 1 cycle: inputs sampled at edge N appear on q and tc after edge N.
- Reset values: q=0, tc=0. The first edge with rst=1 takes effect; asserting rst mid-count or mid-shift discards the operation in that cycle.
- With back-to-back count cycles and no gaps, tc pulses exactly once per MOD edges.
- A mode change takes effect on the next edge with no pipeline residue. For example, count-up at q=MOD-1 followed by a load gives tc=1 for one cycle, then tc=0 with q=d.

## Test plan
- Reset: drive random inputs with en=1 and rst=1 for 3 edges -> q=0, tc=0 after each edge. Release rst -> operation resumes on the next edge.
- Up-count (WIDTH=4, MOD=10): from q=0, 12 up edges -> q runs 1..9, 0, 1, 2. tc=1 only after the edge where q goes 9→0. Load 13, then up -> q=0, tc=1.
- Down-count (MOD=10): load 1, then 3 down edges -> q=0, 9 (tc=1), 8 (tc=0). Load 15, then down -> q=9, tc=0.
- Shifts (WIDTH=4): load 4'b1001. Shift-left with sin_l=1 -> 4'b0011. Shift-right with sin_r=1 -> 4'b1001. Shift-right with sin_r=0 -> 4'b0100.
- JK: q=4'b1010, d=4'b1100, k=4'b0110 -> q=4'b1100. Repeat with d=k=4'b1111 -> q=4'b0011.
- Enable/reset interaction: count up to q=5, drop en for 4 edges -> q stays 5, tc=0. Assert rst together with en=1, mode=up -> q=0.
